// File: rtl/mdl_oob_pkg.sv
// Shared constants and state encoding for the OOB sequencer bench model.
// Primitives are packed first character in the most significant bits.
package mdl_oob_pkg;

    // 10-bit characters, running-disparity-negative forms
    localparam logic [9:0] K28_3 = 10'b0011110011;
    localparam logic [9:0] K28_5 = 10'b0011111010;
    localparam logic [9:0] D10_2 = 10'b0101010101;
    localparam logic [9:0] D21_4 = 10'b1010101101;
    localparam logic [9:0] D21_5 = 10'b1010101010;
    localparam logic [9:0] D23_2 = 10'b1110100101;
    localparam logic [9:0] D27_3 = 10'b1101100011;

    localparam logic [39:0] ALIGN_P = {K28_5, D10_2, D10_2, D27_3};
    localparam logic [39:0] SYNC_P  = {K28_3, D21_4, D21_5, D21_5};
    localparam logic [39:0] X_RDY   = {K28_3, D21_5, D23_2, D23_2};
    localparam logic [39:0] R_RDY   = {K28_3, D21_5, D10_2, D10_2};

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        TX_RST    = 4'd1,
        WAIT_RST  = 4'd2,
        TX_WAKE   = 4'd3,
        WAIT_WAKE = 4'd4,
        ALIGN     = 4'd5,
        SYNC      = 4'd6,
        RRDY      = 4'd7,
        FAIL      = 4'd8
    } oob_state_e;

endpackage

// File: rtl/mdl_oob_burst_gen.sv
// Burst/idle timer for one OOB train: N_BURSTS periods of BURST_LEN active
// clocks followed by the selected idle length.
module mdl_oob_burst_gen #(
    parameter int BURST_LEN     = 160,
    parameter int RST_IDLE_LEN  = 480,
    parameter int WAKE_IDLE_LEN = 160,
    parameter int N_BURSTS      = 6
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       start,
    input  logic       idle_sel,
    output logic       burst_en,
    output logic [3:0] burst_cnt,
    output logic       train_done
);

    localparam int MAX_IDLE = (RST_IDLE_LEN > WAKE_IDLE_LEN) ? RST_IDLE_LEN : WAKE_IDLE_LEN;
    localparam int CW = (BURST_LEN + MAX_IDLE > 2) ? $clog2(BURST_LEN + MAX_IDLE) : 1;
    localparam int BW = (N_BURSTS > 1) ? $clog2(N_BURSTS) : 1;

    localparam logic [CW-1:0] BURST_M1       = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] RST_PERIOD_M1  = CW'(BURST_LEN + RST_IDLE_LEN - 1);
    localparam logic [CW-1:0] WAKE_PERIOD_M1 = CW'(BURST_LEN + WAKE_IDLE_LEN - 1);
    localparam logic [BW-1:0] LAST_BURST     = BW'(N_BURSTS - 1);

    logic          active;
    logic          wake_sel;
    logic [CW-1:0] cyc;
    logic [BW-1:0] bursts;
    logic [CW-1:0] period_m1;
    logic          period_end;

    always_comb begin
        period_m1  = wake_sel ? WAKE_PERIOD_M1 : RST_PERIOD_M1;
        period_end = active && (cyc == period_m1);
        burst_en   = active && (cyc <= BURST_M1);
        train_done = period_end && (bursts == LAST_BURST);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active    <= 1'b0;
            wake_sel  <= 1'b0;
            cyc       <= '0;
            bursts    <= '0;
            burst_cnt <= '0;
        end else if (start) begin
            active    <= 1'b1;
            wake_sel  <= idle_sel;
            cyc       <= '0;
            bursts    <= '0;
            burst_cnt <= '0;
        end else if (active) begin
            if (cyc == BURST_M1 && burst_cnt != 4'hF)
                burst_cnt <= burst_cnt + 4'd1;
            if (period_end) begin
                cyc <= '0;
                if (bursts == LAST_BURST)
                    active <= 1'b0;
                else
                    bursts <= bursts + 1'b1;
            end else begin
                cyc <= cyc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mdl_oob_seq.sv
// Role-selectable SATA OOB sequencer model: COMRESET/COMINIT and COMWAKE
// trains, then ALIGN/SYNC/R_RDY primitive streams with timeout and retry.
module mdl_oob_seq
    import mdl_oob_pkg::*;
#(
    parameter int ROLE_HOST     = 0,
    parameter int P_BITS        = 40,
    parameter int BURST_LEN     = 160,
    parameter int RST_IDLE_LEN  = 480,
    parameter int WAKE_IDLE_LEN = 160,
    parameter int N_BURSTS      = 6,
    parameter int RESP_TIMEOUT  = 65535,
    parameter int RETRY_LIMIT   = 3,
    parameter int RRDY_EN       = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_rst_det,
    input  logic              i_comwake_det,
    input  logic              i_oob_done,
    input  logic              i_link_up,
    output logic              o_burst_en,
    output logic [P_BITS-1:0] o_data,
    output logic [3:0]        o_state,
    output logic [3:0]        o_burst_cnt,
    output logic              o_done,
    output logic              o_fail
);

    localparam bit IS_HOST = (ROLE_HOST != 0);
    localparam bit USE_RRDY = (RRDY_EN != 0);
    localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam int RW = (RETRY_LIMIT > 1) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST    = TW'(RESP_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_LIMIT - 1);

    oob_state_e    state, state_nxt, to_state;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] retry_cnt, retry_nxt;
    logic          done;
    logic          timed, expired, take_to, restart;
    logic          gen_start, gen_burst_en, train_done;

    mdl_oob_burst_gen #(
        .BURST_LEN    (BURST_LEN),
        .RST_IDLE_LEN (RST_IDLE_LEN),
        .WAKE_IDLE_LEN(WAKE_IDLE_LEN),
        .N_BURSTS     (N_BURSTS)
    ) u_burst_gen (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .start     (gen_start),
        .idle_sel  (state_nxt == TX_WAKE),
        .burst_en  (gen_burst_en),
        .burst_cnt (o_burst_cnt),
        .train_done(train_done)
    );

    // Responses are tested before expiry, so a same-cycle response wins.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        take_to   = 1'b0;
        restart   = 1'b0;
        timed     = (state == WAIT_RST) || (state == WAIT_WAKE) || (state == ALIGN);
        expired   = timed && (to_cnt == TO_LAST);
        to_state  = (retry_cnt == RETRY_LAST) ? FAIL : (IS_HOST ? TX_RST : IDLE);
        case (state)
            IDLE:      if (IS_HOST ? i_start : i_rst_det) state_nxt = TX_RST;
            TX_RST:    if (train_done) state_nxt = IS_HOST ? WAIT_RST : WAIT_WAKE;
            WAIT_RST: begin
                if (i_rst_det)    state_nxt = TX_WAKE;
                else if (expired) take_to = 1'b1;
            end
            TX_WAKE:   if (train_done) state_nxt = IS_HOST ? WAIT_WAKE : ALIGN;
            WAIT_WAKE: begin
                if (!IS_HOST && i_rst_det) restart = 1'b1;
                else if (i_comwake_det)    state_nxt = IS_HOST ? ALIGN : TX_WAKE;
                else if (expired)          take_to = 1'b1;
            end
            ALIGN: begin
                if (!IS_HOST && i_rst_det) restart = 1'b1;
                else if (i_oob_done)       state_nxt = SYNC;
                else if (expired)          take_to = 1'b1;
            end
            SYNC: begin
                if (!IS_HOST && i_rst_det)     restart = 1'b1;
                else if (i_link_up && USE_RRDY) state_nxt = RRDY;
            end
            RRDY:      if (!IS_HOST && i_rst_det) restart = 1'b1;
            FAIL:      state_nxt = FAIL;
            default:   state_nxt = IDLE;
        endcase
        if (take_to) begin
            state_nxt = to_state;
            if (retry_cnt != RETRY_LAST) retry_nxt = retry_cnt + 1'b1;
        end
        if (restart) begin
            state_nxt = TX_RST;
            retry_nxt = '0;
        end
        gen_start = (state_nxt != state) && ((state_nxt == TX_RST) || (state_nxt == TX_WAKE));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            retry_cnt <= '0;
            to_cnt    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            retry_cnt <= retry_nxt;
            to_cnt    <= ((state_nxt != state) || !timed) ? '0 : to_cnt + 1'b1;
            if (restart)
                done <= 1'b0;
            else if (state_nxt == ALIGN && state != ALIGN)
                done <= 1'b1;
        end
    end

    always_comb begin
        o_state = state;
        o_done  = done;
        o_fail  = (state == FAIL);
        case (state)
            TX_RST, TX_WAKE:   o_burst_en = gen_burst_en;
            ALIGN, SYNC, RRDY: o_burst_en = 1'b1;
            default:           o_burst_en = 1'b0;
        endcase
        case (state)
            SYNC:    o_data = P_BITS'(SYNC_P);
            RRDY:    o_data = P_BITS'(R_RDY);
            default: o_data = P_BITS'(ALIGN_P);
        endcase
    end

endmodule
